bsg_link_rx_checker: RTL and testbench

- Core-side consumer placed directly downstream of the DDR link downstream stage.
- Takes the recovered 64-bit word stream over valid/yumi and returns yumi itself.
- Optionally throttles yumi to exercise link backpressure and token return.
- Checks the stream against a 64-bit Galois LFSR sequence and reports lock, word count, error count and the first mismatch, for link bring-up and regression.

---
 rtl/bsg_link_rx_checker_pkg.sv | 19 +
 rtl/bsg_link_yumi_throttle.sv | 30 +++
 rtl/bsg_link_rx_checker.sv | 114 +++++++++++
 tb/tb_bsg_link_rx_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_link_rx_checker_pkg.sv
// Shared definitions for the link receive checker and its sibling tx generator:
// the 64-bit Galois LFSR taps, the checker state encoding and the LFSR step.
package bsg_link_rx_checker_pkg;

    // Galois taps for the 64-bit test sequence (x^64 + x^63 + x^61 + x^60 + 1).
    localparam logic [63:0] lfsr_taps = 64'hD800_0000_0000_0000;

    typedef enum logic {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } state_e;

    // One step of the right-shifting Galois LFSR; zero maps to zero, so the
    // zero word can never be a member of a running sequence.
    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return (x >> 1) ^ (x[0] ? lfsr_taps : 64'h0);
    endfunction

endpackage

// File: rtl/bsg_link_yumi_throttle.sv
// Free-running throttle: a counter modulo period_p whose low duty_p counts
// open a window in which a handshake may complete.
module bsg_link_yumi_throttle #(
    parameter int unsigned period_p = 1,
    parameter int unsigned duty_p   = 1
) (
    input  logic clk,
    input  logic rst,
    output logic ok
);

    localparam int unsigned cnt_w = (period_p > 1) ? $clog2(period_p) : 1;
    localparam logic [cnt_w-1:0] last_count = cnt_w'(period_p - 1);

    logic [cnt_w-1:0] count;

    // Counter wraps at period_p - 1; with period_p == 1 it simply stays at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == last_count) begin
            count <= '0;
        end else begin
            count <= count + cnt_w'(1);
        end
    end

    assign ok = (32'(count) < duty_p);

endmodule

// File: rtl/bsg_link_rx_checker.sv
// Core-side consumer for the DDR link: accepts the recovered word stream,
// optionally throttles consumption, and checks it against the 64-bit LFSR
// sequence, reporting lock, word/error counts and the first mismatch.
module bsg_link_rx_checker
    import bsg_link_rx_checker_pkg::*;
#(
    parameter int unsigned width_p     = 64,
    parameter int unsigned period_p    = 1,
    parameter int unsigned duty_p      = 1,
    parameter int unsigned lock_loss_p = 4
) (
    input  logic               core_clk_i,
    input  logic               core_link_reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               yumi_o,
    input  logic               enable_i,
    input  logic               clear_i,
    output logic               locked_o,
    output logic [31:0]        word_count_o,
    output logic [15:0]        error_count_o,
    output logic               error_o,
    output logic [width_p-1:0] first_err_exp_o,
    output logic [width_p-1:0] first_err_got_o
);

    localparam int unsigned consec_w = $clog2(lock_loss_p + 1);
    localparam logic [consec_w-1:0] consec_limit = consec_w'(lock_loss_p);

    state_e              state;
    logic [width_p-1:0]  expected;
    logic [consec_w-1:0] consec_err;
    logic                ok;
    logic                accept;
    logic                mismatch;
    logic [consec_w-1:0] consec_inc;

    bsg_link_yumi_throttle #(
        .period_p (period_p),
        .duty_p   (duty_p)
    ) throttle (
        .clk (core_clk_i),
        .rst (core_link_reset_i),
        .ok  (ok)
    );

    assign yumi_o     = valid_i & enable_i & ok;
    assign accept     = yumi_o;
    assign mismatch   = (data_i != expected);
    assign consec_inc = consec_err + consec_w'(1);

    // Sequence tracking, lock, counters and first-mismatch capture; clear_i
    // is applied last so it overrides any same-cycle increment or capture.
    always_ff @(posedge core_clk_i or posedge core_link_reset_i) begin
        if (core_link_reset_i) begin
            state           <= SYNC;
            expected        <= '0;
            consec_err      <= '0;
            locked_o        <= 1'b0;
            word_count_o    <= '0;
            error_count_o   <= '0;
            error_o         <= 1'b0;
            first_err_exp_o <= '0;
            first_err_got_o <= '0;
        end else begin
            if (accept) begin
                if (word_count_o != 32'hFFFF_FFFF) begin
                    word_count_o <= word_count_o + 32'd1;
                end
                case (state)
                    SYNC: begin
                        if (data_i != '0) begin
                            expected   <= lfsr_next(data_i);
                            locked_o   <= 1'b1;
                            consec_err <= '0;
                            state      <= CHECK;
                        end
                    end
                    CHECK: begin
                        expected <= lfsr_next(expected);
                        if (!mismatch) begin
                            consec_err <= '0;
                        end else begin
                            if (error_count_o != 16'hFFFF) begin
                                error_count_o <= error_count_o + 16'd1;
                            end
                            error_o <= 1'b1;
                            if (!error_o) begin
                                first_err_exp_o <= expected;
                                first_err_got_o <= data_i;
                            end
                            if (consec_inc == consec_limit) begin
                                locked_o   <= 1'b0;
                                state      <= SYNC;
                                consec_err <= '0;
                            end else begin
                                consec_err <= consec_inc;
                            end
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
            if (clear_i) begin
                word_count_o    <= '0;
                error_count_o   <= '0;
                error_o         <= 1'b0;
                first_err_exp_o <= '0;
                first_err_got_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bsg_link_rx_checker.sv
// Directed testbench for bsg_link_rx_checker: a table of single-cycle vectors
// plus hand-written sequences for lock loss, stalls, async reset and throttling.
module tb_bsg_link_rx_checker;

    // Hand-computed LFSR sequence starting from 1.
    localparam logic [63:0] s0  = 64'h0000_0000_0000_0001;
    localparam logic [63:0] s1  = 64'hD800_0000_0000_0000;
    localparam logic [63:0] s2  = 64'h6C00_0000_0000_0000;
    localparam logic [63:0] s3  = 64'h3600_0000_0000_0000;
    localparam logic [63:0] s4  = 64'h1B00_0000_0000_0000;
    localparam logic [63:0] s5  = 64'h0D80_0000_0000_0000;
    localparam logic [63:0] s6  = 64'h06C0_0000_0000_0000;
    localparam logic [63:0] s7  = 64'h0360_0000_0000_0000;
    localparam logic [63:0] s8  = 64'h01B0_0000_0000_0000;
    localparam logic [63:0] s9  = 64'h00D8_0000_0000_0000;
    localparam logic [63:0] s10 = 64'h006C_0000_0000_0000;
    localparam logic [63:0] s11 = 64'h0036_0000_0000_0000;
    localparam logic [63:0] s12 = 64'h001B_0000_0000_0000;
    localparam logic [63:0] s13 = 64'h000D_8000_0000_0000;
    localparam logic [63:0] s14 = 64'h0006_C000_0000_0000;
    localparam logic [63:0] s15 = 64'h0003_6000_0000_0000;
    localparam logic [63:0] s16 = 64'h0001_B000_0000_0000;
    localparam logic [63:0] s17 = 64'h0000_D800_0000_0000;
    localparam logic [63:0] s18 = 64'h0000_6C00_0000_0000;

    logic clk;
    logic rst_a, valid_a, enable_a, clear_a, yumi_a, locked_a, error_a;
    logic [63:0] data_a, fexp_a, fgot_a;
    logic [31:0] wc_a;
    logic [15:0] ec_a;

    logic rst_b, valid_b, enable_b, clear_b, yumi_b, locked_b, error_b;
    logic [63:0] data_b, fexp_b, fgot_b;
    logic [31:0] wc_b;
    logic [15:0] ec_b;

    int compared;
    int mismatched;

    bsg_link_rx_checker #(.width_p(64), .period_p(1), .duty_p(1), .lock_loss_p(4)) dut_a (
        .core_clk_i        (clk),
        .core_link_reset_i (rst_a),
        .data_i            (data_a),
        .valid_i           (valid_a),
        .yumi_o            (yumi_a),
        .enable_i          (enable_a),
        .clear_i           (clear_a),
        .locked_o          (locked_a),
        .word_count_o      (wc_a),
        .error_count_o     (ec_a),
        .error_o           (error_a),
        .first_err_exp_o   (fexp_a),
        .first_err_got_o   (fgot_a)
    );

    bsg_link_rx_checker #(.width_p(64), .period_p(4), .duty_p(1), .lock_loss_p(4)) dut_b (
        .core_clk_i        (clk),
        .core_link_reset_i (rst_b),
        .data_i            (data_b),
        .valid_i           (valid_b),
        .yumi_o            (yumi_b),
        .enable_i          (enable_b),
        .clear_i           (clear_b),
        .locked_o          (locked_b),
        .word_count_o      (wc_b),
        .error_count_o     (ec_b),
        .error_o           (error_b),
        .first_err_exp_o   (fexp_b),
        .first_err_got_o   (fgot_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        enable;
        logic        clear;
        logic [63:0] data;
        logic        exp_yumi;
        logic        exp_locked;
        logic [31:0] exp_wc;
        logic [15:0] exp_ec;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic v, input logic e, input logic c, input logic [63:0] d,
                                input logic y, input logic l, input logic [31:0] w,
                                input logic [15:0] ec, input logic er);
        vec_t r;
        r.valid = v; r.enable = e; r.clear = c; r.data = d;
        r.exp_yumi = y; r.exp_locked = l; r.exp_wc = w; r.exp_ec = ec; r.exp_err = er;
        return r;
    endfunction

    // Compare one value and log a FAIL line when it differs.
    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle on DUT A: set inputs, sample yumi mid-cycle, then pass the edge.
    task automatic apply_stimulus(input logic v, input logic e, input logic c,
                                  input logic [63:0] d, output logic y);
        valid_a  = v;
        enable_a = e;
        clear_a  = c;
        data_a   = d;
        #1;
        y = yumi_a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic l, input logic [31:0] w,
                           input logic [15:0] ec, input logic er);
        check_output({tag, " locked"}, 64'(locked_a), 64'(l));
        check_output({tag, " word_count"}, 64'(wc_a), 64'(w));
        check_output({tag, " error_count"}, 64'(ec_a), 64'(ec));
        check_output({tag, " error"}, 64'(error_a), 64'(er));
    endtask

    initial begin
        logic y;
        logic [63:0] drop_seq[4];
        logic [63:0] next_b;
        int accepts;

        compared   = 0;
        mismatched = 0;

        vecs[0]  = mk(1, 1, 0, s0,  1, 1, 1, 0, 0);
        vecs[1]  = mk(1, 1, 0, s1,  1, 1, 2, 0, 0);
        vecs[2]  = mk(1, 1, 0, s2,  1, 1, 3, 0, 0);
        vecs[3]  = mk(1, 1, 0, s3,  1, 1, 4, 0, 0);
        vecs[4]  = mk(1, 1, 0, 64'h5, 1, 1, 5, 1, 1);
        vecs[5]  = mk(1, 1, 0, s5,  1, 1, 6, 1, 1);
        vecs[6]  = mk(1, 0, 0, s6,  0, 1, 6, 1, 1);
        vecs[7]  = mk(0, 1, 0, s6,  0, 1, 6, 1, 1);
        vecs[8]  = mk(1, 1, 0, s6,  1, 1, 7, 1, 1);
        vecs[9]  = mk(1, 1, 1, 64'h7, 1, 1, 0, 0, 0);
        vecs[10] = mk(1, 1, 0, s8,  1, 1, 1, 0, 0);

        rst_a = 1'b1; valid_a = 0; enable_a = 0; clear_a = 0; data_a = '0;
        rst_b = 1'b1; valid_b = 0; enable_b = 0; clear_b = 0; data_b = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_a("reset", 0, 0, 0, 0);
        check_output("reset first_err_exp", fexp_a, 64'h0);
        rst_a = 1'b0;

        // Table-driven stream: lock, corrupt word, stall, clear against mismatch.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].enable, vecs[i].clear, vecs[i].data, y);
            check_output($sformatf("vec%0d yumi", i), 64'(y), 64'(vecs[i].exp_yumi));
            check_a($sformatf("vec%0d", i), vecs[i].exp_locked, vecs[i].exp_wc,
                    vecs[i].exp_ec, vecs[i].exp_err);
            if (i == 4) begin
                check_output("first_err_exp", fexp_a, s4);
                check_output("first_err_got", fgot_a, 64'h5);
            end
            if (i == 9) begin
                check_output("clear first_err_exp", fexp_a, 64'h0);
                check_output("clear first_err_got", fgot_a, 64'h0);
            end
        end

        // Dropped word (s9 missing): four consecutive errors drop lock.
        drop_seq[0] = s10; drop_seq[1] = s11; drop_seq[2] = s12; drop_seq[3] = s13;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 1, 0, drop_seq[i], y);
            check_a($sformatf("drop%0d", i), (i < 3), 32'(2 + i), 16'(1 + i), 1);
        end
        check_output("drop first_err_exp", fexp_a, s9);
        check_output("drop first_err_got", fgot_a, s10);

        // Relock on the next word; subsequent words match.
        apply_stimulus(1, 1, 0, s14, y);
        check_a("relock", 1, 6, 4, 1);
        apply_stimulus(1, 1, 0, s15, y);
        apply_stimulus(1, 1, 0, s16, y);
        check_a("after relock", 1, 8, 4, 1);

        // Ten cycles with enable low: no consumption, everything frozen.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 0, 0, s17, y);
            check_output($sformatf("stall%0d yumi", i), 64'(y), 64'h0);
        end
        check_a("stall end", 1, 8, 4, 1);
        apply_stimulus(1, 1, 0, s17, y);
        apply_stimulus(1, 1, 0, s18, y);
        check_a("resume", 1, 10, 4, 1);

        // Async reset mid-cycle: outputs clear before any clock edge.
        valid_a = 1'b0;
        rst_a   = 1'b1;
        #1;
        check_a("async reset", 0, 0, 0, 0);
        check_output("async reset first_err_exp", fexp_a, 64'h0);
        check_output("async reset first_err_got", fgot_a, 64'h0);
        check_output("async reset yumi", 64'(yumi_a), 64'h0);
        #1;
        rst_a = 1'b0;

        // Zero word in SYNC is consumed but does not lock.
        apply_stimulus(1, 1, 0, 64'h0, y);
        check_output("zero word yumi", 64'(y), 64'h1);
        check_a("zero word", 0, 1, 0, 0);
        apply_stimulus(1, 1, 0, s0, y);
        check_a("lock after zero", 1, 2, 0, 0);
        valid_a = 1'b0;

        // Throttled instance: period 4, duty 1 -> one accept every 4 cycles.
        @(posedge clk);
        #1;
        rst_b    = 1'b0;
        valid_b  = 1'b1;
        enable_b = 1'b1;
        data_b   = s0;
        accepts  = 0;
        for (int c = 0; c < 32; c++) begin
            #1;
            check_output($sformatf("throttle c%0d yumi", c), 64'(yumi_b), 64'((c % 4) == 0));
            next_b = (yumi_b === 1'b1) ? ((data_b >> 1) ^ (data_b[0] ? s1 : 64'h0)) : data_b;
            if (yumi_b === 1'b1) accepts++;
            @(posedge clk);
            #1;
            data_b = next_b;
        end
        check_output("throttle accepts", 64'(accepts), 64'd8);
        check_output("throttle word_count", 64'(wc_b), 64'd8);
        check_output("throttle error_count", 64'(ec_b), 64'd0);
        check_output("throttle locked", 64'(locked_b), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
